cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one main-memory read port between the I- and
// D-cache fill FSMs, bursting 8 words per block with alternating tie-break.
module cache_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic [15:0] dcache_addr,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  output logic        icache_grant,
  output logic        dcache_grant,
  output logic        icache_data_valid,
  output logic        dcache_data_valid,
  output logic [2:0]  fill_word,
  output logic        icache_done,
  output logic        dcache_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [11:0] base_q, base_d;
  logic [2:0]  iss_q, iss_d;
  logic [2:0]  rx_q, rx_d;
  logic        rx8_q, rx8_d;
  logic        gnt_i_q, gnt_i_d;
  logic        gnt_d_q, gnt_d_d;

  logic        active;
  logic        rx_ok;
  logic        got8;
  logic        pick_d;
  logic        addr_unused;

  assign addr_unused = ^{icache_addr[3:0], dcache_addr[3:0]};

  assign active = (state_q == ISSUE) || (state_q == DRAIN);
  assign rx_ok  = active && mem_data_valid && !rx8_q;
  assign got8   = rx8_q || (rx_ok && (rx_q == 3'd7));
  // on a tie the requester that did not own the last burst wins
  assign pick_d = dcache_req && (!icache_req || !last_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    base_d  = base_q;
    iss_d   = iss_q;
    rx_d    = rx_q;
    rx8_d   = rx8_q;
    gnt_i_d = gnt_i_q;
    gnt_d_d = gnt_d_q;
    if (rx_ok) begin
      rx_d = rx_q + 3'd1;
      if (rx_q == 3'd7) rx8_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (icache_req || dcache_req) begin
          owner_d = pick_d;
          base_d  = pick_d ? dcache_addr[15:4]
                           : icache_addr[15:4];
          gnt_i_d = !pick_d;
          gnt_d_d = pick_d;
          iss_d   = 3'd0;
          rx_d    = 3'd0;
          rx8_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        iss_d = iss_q + 3'd1;
        if (iss_q == 3'd7) state_d = got8 ? DONE : DRAIN;
      end
      DRAIN: begin
        if (got8) state_d = DONE;
      end
      DONE: begin
        last_d  = owner_q;
        iss_d   = 3'd0;
        rx_d    = 3'd0;
        rx8_d   = 1'b0;
        gnt_i_d = 1'b0;
        gnt_d_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      base_q  <= 12'h000;
      iss_q   <= 3'd0;
      rx_q    <= 3'd0;
      rx8_q   <= 1'b0;
      gnt_i_q <= 1'b0;
      gnt_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      base_q  <= base_d;
      iss_q   <= iss_d;
      rx_q    <= rx_d;
      rx8_q   <= rx8_d;
      gnt_i_q <= gnt_i_d;
      gnt_d_q <= gnt_d_d;
    end
  end

  assign mem_enable        = (state_q == ISSUE);
  assign mem_addr          = mem_enable ? {base_q, iss_q, 1'b0}
                                        : 16'h0000;
  assign icache_grant      = gnt_i_q;
  assign dcache_grant      = gnt_d_q;
  assign icache_data_valid = rx_ok && !owner_q;
  assign dcache_data_valid = rx_ok && owner_q;
  assign fill_word         = active ? rx_q : 3'd0;
  assign icache_done       = (state_q == DONE) && !owner_q;
  assign dcache_done       = (state_q == DONE) && owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bursts against a transaction-level model
// of the arbiter, plus hand-computed expectations for each scenario.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req, dcache_req;
  logic [15:0] icache_addr, dcache_addr;
  logic        mem_data_valid;
  logic        mem_enable;
  logic [15:0] mem_addr;
  logic        icache_grant, dcache_grant;
  logic        icache_data_valid, dcache_data_valid;
  logic [2:0]  fill_word;
  logic        icache_done, dcache_done;

  cache_mem_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .icache_req        (icache_req),
    .icache_addr       (icache_addr),
    .dcache_req        (dcache_req),
    .dcache_addr       (dcache_addr),
    .mem_data_valid    (mem_data_valid),
    .mem_enable        (mem_enable),
    .mem_addr          (mem_addr),
    .icache_grant      (icache_grant),
    .dcache_grant      (dcache_grant),
    .icache_data_valid (icache_data_valid),
    .dcache_data_valid (dcache_data_valid),
    .fill_word         (fill_word),
    .icache_done       (icache_done),
    .dcache_done       (dcache_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = 0;

  // memory: fixed latency per burst, optional stall, optional stray valid
  int lat = 4;
  bit stall = 0;
  bit stray = 0;
  bit hold = 0;
  int q[$];

  // model: who owns the port, words issued and words received so far
  bit          m_busy, m_owner, m_last;
  logic [11:0] m_base;
  int          m_iss, m_rcv;

  logic [15:0] addr_log[$];
  int          fill_log[$];
  int          owner_log[$];
  int strobes, done_i, done_d, en_first, en_last;
  int last_strobe, done_cyc, gi_rise, dd_cyc;
  bit prev_gi, saw_done;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [25:0] got_vec();
    return {mem_enable, mem_addr, icache_grant, dcache_grant,
            icache_data_valid, dcache_data_valid, fill_word,
            icache_done, dcache_done};
  endfunction

  function automatic logic [25:0] exp_vec();
    bit fin, act, en, dv;
    logic [2:0]  iss3, fw;
    logic [15:0] a;
    fin  = m_busy && m_iss == 8 && m_rcv == 8;
    act  = m_busy && !fin;
    en   = m_busy && m_iss < 8;
    iss3 = 3'(m_iss % 8);
    a    = en ? {m_base, iss3, 1'b0} : 16'h0000;
    dv   = act && mem_data_valid && m_rcv < 8;
    fw   = act ? 3'(m_rcv % 8) : 3'd0;
    return {en, a, m_busy && !m_owner, m_busy && m_owner,
            dv && !m_owner, dv && m_owner, fw,
            fin && !m_owner, fin && m_owner};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 0;
    m_base = '0; m_iss = 0; m_rcv = 0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (icache_req || dcache_req) begin
        m_owner = (icache_req && dcache_req) ? !m_last : dcache_req;
        m_base  = m_owner ? dcache_addr[15:4] : icache_addr[15:4];
        m_busy  = 1; m_iss = 0; m_rcv = 0;
      end
    end else if (m_iss == 8 && m_rcv == 8) begin
      m_last = m_owner;
      m_busy = 0;
    end else begin
      if (mem_data_valid && m_rcv < 8) m_rcv++;
      if (m_iss < 8) m_iss++;
    end
  endtask

  task automatic clear_logs();
    addr_log.delete(); fill_log.delete(); owner_log.delete();
    strobes = 0; done_i = 0; done_d = 0;
    en_first = -1; en_last = -1; last_strobe = -1;
    done_cyc = -1; gi_rise = -1; dd_cyc = -1;
  endtask

  task automatic cyc();
    bit mv;
    @(negedge clk);
    n++;
    if (!hold && icache_done) icache_req = 0;
    if (!hold && dcache_done) dcache_req = 0;
    if (mem_enable) q.push_back(n + lat);
    mv = 0;
    if (stray) mv = 1;
    else if (!stall && q.size() > 0 && q[0] <= n) begin
      mv = 1;
      void'(q.pop_front());
    end
    mem_data_valid = mv;
    #1;
    chk($sformatf("cycle%0d", n), 32'(got_vec()), 32'(exp_vec()));
    if (mem_enable) begin
      addr_log.push_back(mem_addr);
      if (en_first < 0) en_first = n;
      en_last = n;
    end
    if (icache_data_valid || dcache_data_valid) begin
      fill_log.push_back(int'(fill_word));
      strobes++;
      last_strobe = n;
    end
    if (icache_done) begin
      done_i++; owner_log.push_back(0); done_cyc = n; saw_done = 1;
    end
    if (dcache_done) begin
      done_d++; owner_log.push_back(1); done_cyc = n; saw_done = 1;
      dd_cyc = n;
    end
    if (icache_grant && !prev_gi && gi_rise < 0) gi_rise = n;
    prev_gi = icache_grant;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string nm, int max, int st_at = -1,
                           int st_len = 0);
    saw_done = 0;
    for (int i = 0; i < max; i++) begin
      stall = (i >= st_at) && (i < st_at + st_len);
      cyc();
      if (saw_done) break;
    end
    stall = 0;
    checks++;
    if (!saw_done) begin
      errors++;
      $display("FAIL %s timeout got=no_done exp=done within %0d", nm, max);
    end
  endtask

  task automatic pulse_reset(string nm);
    rst_n = 0;
    icache_req = 0; dcache_req = 0;
    mem_data_valid = 0; stray = 0;
    #1;
    chk(nm, 32'(got_vec()), 32'd0);
    model_reset();
    q.delete();
    prev_gi = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1;
    icache_req = 0; dcache_req = 0;
    icache_addr = 0; dcache_addr = 0;
    mem_data_valid = 0;
    model_reset();
    clear_logs();
    prev_gi = 0;
    #1 rst_n = 0;
    #1 chk("reset_outputs", 32'(got_vec()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;

    // single I-cache miss at 0x1234, latency 4
    clear_logs();
    lat = 4; icache_addr = 16'h1234; icache_req = 1;
    wait_done("r29", 40);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("r29_addr%0d", k),
          32'(addr_log.size() > k ? addr_log[k] : 16'hFFFF),
          32'h1230 + 32'(2 * k));
      chk($sformatf("r29_fill%0d", k),
          32'(fill_log.size() > k ? fill_log[k] : -1), 32'(k));
    end
    chk("r29_consecutive", 32'(en_last - en_first), 32'd7);
    chk("r29_strobes", 32'(strobes), 32'd8);
    chk("r29_done_i", 32'(done_i), 32'd1);
    chk("r29_done_d", 32'(done_d), 32'd0);

    // tie straight after reset: D first, then I on the next idle
    pulse_reset("r30_reset_zero");
    clear_logs();
    lat = 2;
    icache_addr = 16'h4000; dcache_addr = 16'h8000;
    icache_req = 1; dcache_req = 1;
    wait_done("r30_first", 40);
    wait_done("r30_second", 40);
    chk("r30_owner0", 32'(owner_log.size() > 0 ? owner_log[0] : -1), 1);
    chk("r30_owner1", 32'(owner_log.size() > 1 ? owner_log[1] : -1), 0);
    chk("r30_igrant_gap", 32'(gi_rise - dd_cyc), 32'd2);

    // persistent tie across four bursts alternates owners
    clear_logs();
    lat = 3;
    icache_addr = 16'h2A5F; dcache_addr = 16'hF00C;
    hold = 1; icache_req = 1; dcache_req = 1;
    for (int b = 0; b < 4; b++) wait_done("r31", 40);
    hold = 0; icache_req = 0; dcache_req = 0;
    for (int b = 0; b < 4; b++)
      chk($sformatf("r31_owner%0d", b),
          32'(owner_log.size() > b ? owner_log[b] : -1),
          32'((b % 2 == 0) ? 1 : 0));

    // latency 1, latency 10 with a stall gap, latency 0
    clear_logs();
    lat = 1; dcache_addr = 16'h0010; dcache_req = 1;
    wait_done("r32_lat1", 40);
    chk("r32_lat1_strobes", 32'(strobes), 32'd8);
    chk("r32_lat1_done", 32'(done_d), 32'd1);
    clear_logs();
    lat = 10; icache_addr = 16'hBEEF; icache_req = 1;
    wait_done("r32_lat10", 60, 13, 3);
    chk("r32_lat10_strobes", 32'(strobes), 32'd8);
    chk("r32_lat10_after8", 32'(done_cyc - last_strobe), 32'd1);
    clear_logs();
    lat = 0; dcache_addr = 16'h7770; dcache_req = 1;
    wait_done("r32_lat0", 40);
    chk("r32_lat0_strobes", 32'(strobes), 32'd8);
    chk("r32_lat0_after8", 32'(done_cyc - last_strobe), 32'd1);

    // stray valid while idle
    clear_logs();
    stray = 1; cyc(); stray = 0; cyc();
    chk("r33_no_strobe", 32'(strobes), 32'd0);
    lat = 3; dcache_addr = 16'h0150; dcache_req = 1;
    wait_done("r33_burst", 40);
    chk("r33_fill0", 32'(fill_log.size() > 0 ? fill_log[0] : -1), 0);
    chk("r33_strobes", 32'(strobes), 32'd8);

    // reset while the third address is on the bus
    clear_logs();
    lat = 2;
    icache_addr = 16'h3330; dcache_addr = 16'h5550;
    icache_req = 1; dcache_req = 1;
    cyc(); cyc(); cyc();
    chk("r34_third_addr", 32'({mem_enable, mem_addr[3:1]}), 32'h0A);
    pulse_reset("r34_async_zero");
    cyc(); cyc();
    chk("r34_no_done", 32'(done_i + done_d), 32'd0);
    icache_req = 1; dcache_req = 1;
    wait_done("r34_after", 40);
    chk("r34_owner", 32'(owner_log.size() > 0 ? owner_log[0] : -1), 1);
    icache_req = 0; dcache_req = 0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
